// File: rtl/e_mdu.sv
// HI/LO multiply/divide unit: fixed-latency mult (5 cycles) and optional divide (10 cycles).
// Define MDU_DIV_EN to include the divider; otherwise div/divu behave as a no-op.
module e_mdu (
    input  logic        Emdu_clk_E_i,
    input  logic        Emdu_rstn_E_i,
    input  logic        Emdu_start_E_i,
    input  logic [2:0]  Emdu_op_E_i,
    input  logic [31:0] Emdu_rsd_E_i,
    input  logic [31:0] Emdu_rtd_E_i,
    output logic        Emdu_busy_E_o,
    output logic [31:0] Emdu_hi_E_o,
    output logic [31:0] Emdu_lo_E_o
);
    // state   | meaning
    // ST_IDLE | ready to accept; mthi/mtlo complete here
    // ST_MUL  | mult/multu counting down, result on last cycle
    // ST_DIV  | div/divu counting down, result on last cycle
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic [31:0] rs_q, rs_d, rt_q, rt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] ext_a, ext_b, prod;

    always_comb begin
        ext_a = sgn_q ? {{32{rs_q[31]}}, rs_q} : {32'd0, rs_q};
        ext_b = sgn_q ? {{32{rt_q[31]}}, rt_q} : {32'd0, rt_q};
        prod  = ext_a * ext_b;
    end

`ifdef MDU_DIV_EN
    logic [31:0] mag_a, mag_b, dvsr, quo_mag, rem_mag, quo, rem;

    // Divide on magnitudes, then fix signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000.
    always_comb begin
        mag_a   = (sgn_q && rs_q[31]) ? (~rs_q + 32'd1) : rs_q;
        mag_b   = (sgn_q && rt_q[31]) ? (~rt_q + 32'd1) : rt_q;
        dvsr    = (rt_q == 32'd0) ? 32'd1 : mag_b;
        quo_mag = mag_a / dvsr;
        rem_mag = mag_a % dvsr;
        quo     = (sgn_q && (rs_q[31] ^ rt_q[31])) ? (~quo_mag + 32'd1) : quo_mag;
        rem     = (sgn_q && rs_q[31]) ? (~rem_mag + 32'd1) : rem_mag;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Emdu_start_E_i) begin
                    case (Emdu_op_E_i)
                        OP_MULT, OP_MULTU: begin
                            state_d = ST_MUL;
                            cnt_d   = 4'd5;
                            sgn_d   = (Emdu_op_E_i == OP_MULT);
                            rs_d    = Emdu_rsd_E_i;
                            rt_d    = Emdu_rtd_E_i;
                        end
`ifdef MDU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            state_d = ST_DIV;
                            cnt_d   = 4'd10;
                            sgn_d   = (Emdu_op_E_i == OP_DIV);
                            rs_d    = Emdu_rsd_E_i;
                            rt_d    = Emdu_rtd_E_i;
                        end
`endif
                        OP_MTHI: hi_d = Emdu_rsd_E_i;
                        OP_MTLO: lo_d = Emdu_rsd_E_i;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                end
            end
            ST_DIV: begin
`ifdef MDU_DIV_EN
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    if (rt_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
`else
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Emdu_clk_E_i or negedge Emdu_rstn_E_i) begin
        if (!Emdu_rstn_E_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            sgn_q   <= 1'b0;
            rs_q    <= 32'd0;
            rt_q    <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Emdu_busy_E_o = (state_q != ST_IDLE);
    assign Emdu_hi_E_o   = hi_q;
    assign Emdu_lo_E_o   = lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: vector table plus hand sequences for busy-start, reset abort
// and post-reset accept. Expected divide results depend on MDU_DIV_EN.
module tb_e_mdu;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rsd = 32'd0, rtd = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;

`ifdef MDU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    e_mdu dut (
        .Emdu_clk_E_i  (clk),
        .Emdu_rstn_E_i (rstn),
        .Emdu_start_E_i(start),
        .Emdu_op_E_i   (op),
        .Emdu_rsd_E_i  (rsd),
        .Emdu_rtd_E_i  (rtd),
        .Emdu_busy_E_o (busy),
        .Emdu_hi_E_o   (hi),
        .Emdu_lo_E_o   (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one start pulse at the negedge; returns just after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rsd   = a;
        rtd   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        rsd   = 32'h5A5A_A5A5;
        rtd   = 32'hC3C3_3C3C;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        logic [31:0] ph, pl;

        vecs[0]  = '{3'd5, 32'hAAAA5555, 32'h0, 0, 32'hAAAA5555, 32'h0};
        vecs[1]  = '{3'd6, 32'h00001234, 32'h0, 0, 32'hAAAA5555, 32'h00001234};
        vecs[2]  = '{3'd1, 32'hFFFFFFFE, 32'h3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'h2, 5, 32'h00000001, 32'hFFFFFFFE};
        vecs[4]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, DIV_ON ? 10 : 0,
                     32'h00000001, DIV_ON ? 32'hFFFFFFFD : 32'hFFFFFFFE};
        vecs[5]  = '{3'd4, 32'h80000000, 32'h3, DIV_ON ? 10 : 0,
                     DIV_ON ? 32'h2 : 32'h1, DIV_ON ? 32'h2AAAAAAA : 32'hFFFFFFFE};
        vecs[6]  = '{3'd4, 32'h5, 32'h0, DIV_ON ? 10 : 0,
                     DIV_ON ? 32'h2 : 32'h1, DIV_ON ? 32'h2AAAAAAA : 32'hFFFFFFFE};
        vecs[7]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, DIV_ON ? 10 : 0,
                     DIV_ON ? 32'h0 : 32'h1, DIV_ON ? 32'h80000000 : 32'hFFFFFFFE};
        vecs[8]  = '{3'd0, 32'h11111111, 32'h2, 0, vecs[7].hi, vecs[7].lo};
        vecs[9]  = '{3'd7, 32'h22222222, 32'h3, 0, vecs[7].hi, vecs[7].lo};
        vecs[10] = '{3'd1, 32'hFFFFFFFB, 32'hFFFFFFF9, 5, 32'h0, 32'h00000023};
        vecs[11] = '{3'd1, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h0};
        vecs[12] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001};
        vecs[13] = '{3'd3, 32'hFFFFFFF9, 32'h2, DIV_ON ? 10 : 0,
                     DIV_ON ? 32'hFFFFFFFF : 32'hFFFFFFFE, DIV_ON ? 32'hFFFFFFFD : 32'h00000001};

        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        ph = 32'd0;
        pl = 32'd0;
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
            if (vecs[i].cyc > 0) begin
                chk($sformatf("v%0d hi held", i), hi, ph);
                chk($sformatf("v%0d lo held", i), lo, pl);
            end
            count_busy(n);
            chk($sformatf("v%0d busy cycles", i), n, vecs[i].cyc);
            chk($sformatf("v%0d hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d lo", i), lo, vecs[i].lo);
            ph = vecs[i].hi;
            pl = vecs[i].lo;
        end

        // Start while busy is ignored: mthi during a mult must not land.
        issue(3'd6, 32'h00001234, 32'h0);
        issue(3'd1, 32'h3, 32'h4);
        @(posedge clk);
        #1;
        issue(3'd5, 32'hDEADBEEF, 32'h0);
        chk("busy-start hi held", hi, ph);
        chk("busy-start lo held", lo, 32'h00001234);
        count_busy(n);
        chk("busy-start remaining cycles", n, 3);
        chk("busy-start hi", hi, 32'h0);
        chk("busy-start lo", lo, 32'h0000000C);

        // Reset three cycles into a long operation.
        issue(3'd5, 32'h0BAD0BAD, 32'h0);
        issue(DIV_ON ? 3'd3 : 3'd1, 32'd100, 32'd7);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        repeat (3) @(posedge clk);
        // Release and accept an mthi on the very first rising edge.
        @(negedge clk);
        rstn  = 1'b1;
        start = 1'b1;
        op    = 3'd5;
        rsd   = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        chk("first-edge accept hi", hi, 32'hCAFEF00D);
        repeat (12) @(posedge clk);
        #1;
        chk("post-abort busy", {31'd0, busy}, 32'd0);
        chk("post-abort hi", hi, 32'hCAFEF00D);
        chk("post-abort lo", lo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have port Emdu_clk_E_i, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port Emdu_rstn_E_i, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Emdu_start_E_i, input, 1, qualifies Emdu_op_E_i for one cycle.
REQ-004 SHALL have port Emdu_op_E_i, input, 3, operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-005 SHALL have port Emdu_rsd_E_i, input, 32, forwarded rs operand from the E-stage pipeline register.
REQ-006 SHALL have port Emdu_rtd_E_i, input, 32, forwarded rt operand from the E-stage pipeline register.
REQ-007 SHALL have port Emdu_busy_E_o, output, 1, operation in progress; drives the decode-stage stall.
REQ-008 SHALL have port Emdu_hi_E_o, output, 32, architectural HI register.
REQ-009 SHALL have port Emdu_lo_E_o, output, 32, architectural LO register.

Function
REQ-010 Accept condition SHALL be: start=1, busy=0, op valid; start while busy=1 is ignored with no state change.
REQ-011 On an accepted mult/multu: busy SHALL rise at the same edge; counter loaded with 5; busy stays high exactly 5 cycles.
REQ-012 On an accepted div/divu: busy SHALL rise at the same edge; counter loaded with 10; busy stays high exactly 10 cycles.
REQ-013 Operands SHALL be captured at the accept edge; later changes on rsd/rtd do not affect the result.
REQ-014 Each edge while busy, counter SHALL decrement; at the edge where counter==1, busy falls and HI/LO update in the same edge.
REQ-015 mult: {HI,LO} SHALL be the 64-bit two's-complement product; multu: 64-bit unsigned product.
REQ-016 div: LO SHALL be the signed quotient truncated toward zero and HI the remainder, with the sign of the remainder equal to the sign of the dividend; divu: unsigned quotient and remainder.
REQ-017 Divide with rtd==0 SHALL still run 10 cycles and leave HI/LO unchanged.
REQ-018 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-019 mthi/mtlo SHALL write rsd into HI/LO at the accept edge, with no busy assertion.
REQ-020 Op 0/7 with start=1 SHALL cause no state change.
REQ-021 HI/LO outputs SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-022 Asserting rstn low SHALL immediately clear busy, counter, HI and LO to 0, including mid-operation; the aborted result is discarded.
REQ-023 After rstn deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-024 Macro MDU_DIV_EN SHALL control the divider: defined, div/divu behave per REQ-012/016/017/018; undefined, the divider logic is absent and div/divu are treated as op 0 (busy stays 0, HI/LO unchanged).

Verification
REQ-025 mult rsd=0xFFFFFFFE, rtd=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-026 multu rsd=0xFFFFFFFF, rtd=2 -> after 5 cycles, HI=0x00000001, LO=0xFFFFFFFE.
REQ-027 div rsd=7, rtd=0xFFFFFFFE -> busy 10 cycles, LO=0xFFFFFFFD, HI=1; divu rsd=0x80000000, rtd=3 -> LO=0x2AAAAAAA, HI=2; without MDU_DIV_EN -> busy stays 0, HI/LO unchanged.
REQ-028 mtlo rsd=0x1234 then mult started; second start (mthi) issued while busy -> ignored; HI/LO hold until the mult completes.
REQ-029 divu rsd=5, rtd=0 -> busy 10 cycles, HI/LO retain the prior values.
REQ-030 rstn pulled low 3 cycles into a div -> busy, HI and LO are 0 immediately; no late update after release.
